// File: rtl/pkt_tx_generator_pkg.sv
// Shared definitions for the packet transmit generator: FSM encoding, IOQ
// control bytes, module-header layout and the final-word ctrl helper.
package pkt_tx_generator_pkg;

  localparam int unsigned DWIDTH     = 64;
  localparam int unsigned CTRL_WIDTH = DWIDTH / 8;
  localparam int unsigned HDR_WORDS  = 6;
  localparam int unsigned MAX_LEN    = 2048;

  localparam logic [7:0] IOQ_CTRL  = 8'hFF;
  localparam logic [7:0] DATA_CTRL = 8'h00;

  // Bit offsets of the IOQ module-header fields (shared with headerparser).
  localparam int unsigned IOQ_DST_PORT_POS = 48;
  localparam int unsigned IOQ_WORD_LEN_POS = 32;
  localparam int unsigned IOQ_BYTE_LEN_POS = 0;

  // IOQ module-header word; field order matches the offsets above.
  typedef struct packed {
    logic [15:0] dst_port;
    logic [15:0] word_len;
    logic [15:0] rsvd;
    logic [15:0] byte_len;
  } ioq_hdr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOD_HDR = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } tx_state_e;

  // Final-word ctrl: one-hot marking the last valid byte (v=8 -> 01, v=1 -> 80).
  function automatic logic [7:0] last_ctrl_f(input logic [3:0] valid_bytes);
    return 8'h01 << (4'd8 - valid_bytes);
  endfunction

endpackage

// File: rtl/pkt_tx_generator_len_calc.sv
// Frame geometry from the latched byte length.
//  byte_len_i   frame byte length L
//  word_cnt_o   W = ceil(L/8)
//  last_ctrl_o  ctrl byte for the final frame word
//  byte_mask_o  data mask keeping only the valid bytes of the final word
module pkt_tx_generator_len_calc
  import pkt_tx_generator_pkg::*;
(
  input  logic [15:0] byte_len_i,
  output logic [15:0] word_cnt_o,
  output logic [7:0]  last_ctrl_o,
  output logic [63:0] byte_mask_o
);

  logic [3:0] last_valid;
  logic [5:0] mask_shamt;

  always_comb begin
    word_cnt_o  = 16'((17'(byte_len_i) + 17'd7) >> 3);
    last_valid  = (byte_len_i[2:0] == 3'd0) ? 4'd8 : {1'b0, byte_len_i[2:0]};
    last_ctrl_o = last_ctrl_f(last_valid);
    // Byte 0 sits in [63:56], so invalid tail bytes are the low-order ones.
    mask_shamt  = {3'(4'd8 - last_valid), 3'b000};
    byte_mask_o = {64{1'b1}} << mask_shamt;
  end

endmodule

// File: rtl/pkt_tx_generator.sv
// On-chip packet source emitting IOQ module header, header template words and
// generated payload on a 64-bit data/ctrl/wr/rdy bus with backpressure.
//  i_clock/i_reset_n         clock, async active-low reset
//  hdr_wr_*                  header template write port (dropped while busy)
//  cfg_*                     run configuration, latched on accepted start
//  start/stop                run control pulses
//  out_data/out_ctrl/out_wr  packet word bus; out_rdy is downstream accept
//  busy/cfg_err/pkt_count    status
module pkt_tx_generator
  import pkt_tx_generator_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  hdr_wr_en,
  input  logic [2:0]            hdr_wr_addr,
  input  logic [DWIDTH-1:0]     hdr_wr_data,
  input  logic [15:0]           cfg_byte_len,
  input  logic [15:0]           cfg_num_pkts,
  input  logic [7:0]            cfg_gap,
  input  logic [15:0]           cfg_dst_port,
  input  logic                  start,
  input  logic                  stop,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  busy,
  output logic                  cfg_err,
  output logic [31:0]           pkt_count
);

  tx_state_e   state_q, state_d;
  logic [15:0] widx_q, widx_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [15:0] pkts_done_q, pkts_done_d;
  logic [15:0] len_q, len_d;
  logic [15:0] num_q, num_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] dst_q, dst_d;
  logic        stop_seen_q, stop_seen_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  out_ctrl_q, out_ctrl_d;
  logic        out_wr_q, out_wr_d;
  logic        busy_q, busy_d;
  logic        cfg_err_q, cfg_err_d;
  logic [31:0] pkt_count_q, pkt_count_d;

  logic [63:0] tmpl_q [HDR_WORDS];

  logic [15:0] word_cnt;
  logic [7:0]  last_ctrl;
  logic [63:0] byte_mask;
  logic [63:0] raw_word;
  logic        is_last;
  logic        pkt_done;
  logic        run_done;
  logic        len_bad;
  ioq_hdr_t    mod_hdr;

  pkt_tx_generator_len_calc u_len_calc (
    .byte_len_i  (len_q),
    .word_cnt_o  (word_cnt),
    .last_ctrl_o (last_ctrl),
    .byte_mask_o (byte_mask)
  );

  // Header template register file; contents are not reset.
  always_ff @(posedge i_clock) begin
    if (hdr_wr_en && !busy_q && (hdr_wr_addr < 3'(HDR_WORDS))) begin
      tmpl_q[hdr_wr_addr] <= hdr_wr_data;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    gap_cnt_d   = gap_cnt_q;
    pkts_done_d = pkts_done_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_d       = gap_q;
    dst_d       = dst_q;
    stop_seen_d = stop_seen_q;
    out_data_d  = out_data_q;
    out_ctrl_d  = out_ctrl_q;
    out_wr_d    = 1'b0;
    cfg_err_d   = 1'b0;
    pkt_count_d = pkt_count_q;
    raw_word    = '0;
    pkt_done    = 1'b0;
    is_last     = (widx_q == (word_cnt - 16'd1));
    len_bad     = (cfg_byte_len < 16'(HDR_WORDS * 8)) || (cfg_byte_len > 16'(MAX_LEN));
    run_done    = ((num_q != 16'd0) && ((pkts_done_q + 16'd1) == num_q)) ||
                  stop_seen_q || stop;
    mod_hdr     = '{dst_port: dst_q, word_len: word_cnt, rsvd: 16'h0000, byte_len: len_q};

    // A stop during a packet is remembered until the packet ends.
    if (state_q != ST_IDLE && stop) begin
      stop_seen_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            len_d       = cfg_byte_len;
            num_d       = cfg_num_pkts;
            gap_d       = cfg_gap;
            dst_d       = cfg_dst_port;
            pkts_done_d = '0;
            stop_seen_d = 1'b0;
            state_d     = ST_MOD_HDR;
          end
        end
      end
      ST_MOD_HDR: begin
        if (out_rdy) begin
          out_wr_d   = 1'b1;
          out_data_d = mod_hdr;
          out_ctrl_d = IOQ_CTRL;
          widx_d     = '0;
          state_d    = ST_HDR;
        end
      end
      ST_HDR, ST_PAYLOAD: begin
        if (out_rdy) begin
          out_wr_d = 1'b1;
          raw_word = (state_q == ST_HDR) ? tmpl_q[widx_q[2:0]] : {pkt_count_q, 32'(widx_q)};
          if (is_last) begin
            out_data_d = raw_word & byte_mask;
            out_ctrl_d = last_ctrl;
            pkt_done   = 1'b1;
          end else begin
            out_data_d = raw_word;
            out_ctrl_d = DATA_CTRL;
            widx_d     = widx_q + 16'd1;
            if (state_q == ST_HDR && widx_q == 16'(HDR_WORDS - 1)) begin
              state_d = ST_PAYLOAD;
            end
          end
        end
      end
      ST_GAP: begin
        if (stop || stop_seen_q) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q <= 8'd1) begin
          state_d = ST_MOD_HDR;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // End of frame: count it and pick gap, next packet or end of run.
    if (pkt_done) begin
      pkt_count_d = pkt_count_q + 32'd1;
      pkts_done_d = pkts_done_q + 16'd1;
      if (run_done) begin
        state_d = ST_IDLE;
      end else if (gap_q == 8'd0) begin
        state_d = ST_MOD_HDR;
      end else begin
        gap_cnt_d = gap_q;
        state_d   = ST_GAP;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      gap_cnt_q   <= '0;
      pkts_done_q <= '0;
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      dst_q       <= '0;
      stop_seen_q <= 1'b0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      gap_cnt_q   <= gap_cnt_d;
      pkts_done_q <= pkts_done_d;
      len_q       <= len_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      dst_q       <= dst_d;
      stop_seen_q <= stop_seen_d;
      out_data_q  <= out_data_d;
      out_ctrl_q  <= out_ctrl_d;
      out_wr_q    <= out_wr_d;
      busy_q      <= busy_d;
      cfg_err_q   <= cfg_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_wr    = out_wr_q;
  assign busy      = busy_q;
  assign cfg_err   = cfg_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pkt_tx_generator.sv
// Self-checking bench for pkt_tx_generator: a table of run configurations with
// hand-computed frame geometry, plus directed sequences for error, stop,
// busy-start and reset corner cases.
module tb_pkt_tx_generator;

  logic        clk;
  logic        i_reset_n;
  logic        hdr_wr_en;
  logic [2:0]  hdr_wr_addr;
  logic [63:0] hdr_wr_data;
  logic [15:0] cfg_byte_len;
  logic [15:0] cfg_num_pkts;
  logic [7:0]  cfg_gap;
  logic [15:0] cfg_dst_port;
  logic        start;
  logic        stop;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        busy;
  logic        cfg_err;
  logic [31:0] pkt_count;

  pkt_tx_generator dut (
    .i_clock      (clk),
    .i_reset_n    (i_reset_n),
    .hdr_wr_en    (hdr_wr_en),
    .hdr_wr_addr  (hdr_wr_addr),
    .hdr_wr_data  (hdr_wr_data),
    .cfg_byte_len (cfg_byte_len),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_gap      (cfg_gap),
    .cfg_dst_port (cfg_dst_port),
    .start        (start),
    .stop         (stop),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .busy         (busy),
    .cfg_err      (cfg_err),
    .pkt_count    (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         num;
    int         gap;
    bit         rnd;
    int         exp_w;
    logic [7:0] exp_lc;
  } vec_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic [63:0] tmpl_v [6];
  logic [63:0] cap_d [$];
  logic [7:0]  cap_c [$];
  int          cap_t [$];
  vec_t        tbl [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every written word with its cycle stamp.
  always @(negedge clk) begin
    if (i_reset_n && out_wr) begin
      cap_d.push_back(out_data);
      cap_c.push_back(out_ctrl);
      cap_t.push_back(cyc);
    end
  end

  // Downstream ready: steady 1 or random toggling.
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_cap();
    cap_d.delete();
    cap_c.delete();
    cap_t.delete();
  endtask

  task automatic wr_tmpl();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      hdr_wr_en   = 1'b1;
      hdr_wr_addr = 3'(i);
      hdr_wr_data = tmpl_v[i];
    end
    @(posedge clk);
    #1;
    hdr_wr_en = 1'b0;
  endtask

  task automatic start_run(input int len, input int num, input int gap);
    @(posedge clk);
    #1;
    cfg_byte_len = 16'(len);
    cfg_num_pkts = 16'(num);
    cfg_gap      = 8'(gap);
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle_timeout"}, 64'(n >= 20000), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_words(input string name, input int cnt);
    int n = 0;
    while (cap_d.size() < cnt && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, " word_timeout"}, 64'(n >= 5000), 64'd0);
  endtask

  // Compare captured words against the frame model.
  task automatic check_capture(input string tag, input int len, input int num, input int w,
                               input logic [7:0] lc, input int gap, input bit chk_t,
                               input int base);
    int          tot;
    int          v;
    int          p;
    int          j;
    int          k;
    logic [63:0] mask;
    logic [63:0] ed;
    logic [7:0]  ec;
    tot  = num * (w + 1);
    v    = (len % 8 == 0) ? 8 : len % 8;
    mask = '1;
    mask = mask << (8 * (8 - v));
    check($sformatf("%s words", tag), 64'(cap_d.size()), 64'(tot));
    for (int i = 0; i < tot && i < cap_d.size(); i++) begin
      p = i / (w + 1);
      j = i % (w + 1);
      if (j == 0) begin
        ed = {16'h0004, 16'(w), 16'h0000, 16'(len)};
        ec = 8'hFF;
      end else begin
        k  = j - 1;
        ed = (k < 6) ? tmpl_v[k] : {32'(base + p), 32'(k)};
        ec = 8'h00;
        if (k == w - 1) begin
          ed = ed & mask;
          ec = lc;
        end
      end
      check($sformatf("%s p%0d w%0d data", tag, p, j), cap_d[i], ed);
      check($sformatf("%s p%0d w%0d ctrl", tag, p, j), 64'(cap_c[i]), 64'(ec));
    end
    if (chk_t && cap_d.size() == tot) begin
      for (int q = 0; q < num; q++) begin
        check($sformatf("%s p%0d contiguous", tag, q),
              64'(cap_t[q * (w + 1) + w] - cap_t[q * (w + 1)]), 64'(w));
        if (q > 0) begin
          check($sformatf("%s p%0d gap", tag, q),
                64'(cap_t[q * (w + 1)] - cap_t[q * (w + 1) - 1]), 64'(gap + 1));
        end
      end
    end
  endtask

  initial begin
    tbl[0] = '{len: 64,   num: 1, gap: 0, rnd: 1'b0, exp_w: 8,   exp_lc: 8'h01};
    tbl[1] = '{len: 61,   num: 2, gap: 3, rnd: 1'b0, exp_w: 8,   exp_lc: 8'h08};
    tbl[2] = '{len: 100,  num: 1, gap: 0, rnd: 1'b0, exp_w: 13,  exp_lc: 8'h10};
    tbl[3] = '{len: 100,  num: 2, gap: 1, rnd: 1'b1, exp_w: 13,  exp_lc: 8'h10};
    tbl[4] = '{len: 48,   num: 1, gap: 0, rnd: 1'b0, exp_w: 6,   exp_lc: 8'h01};
    tbl[5] = '{len: 49,   num: 1, gap: 2, rnd: 1'b1, exp_w: 7,   exp_lc: 8'h80};
    tbl[6] = '{len: 2048, num: 1, gap: 0, rnd: 1'b0, exp_w: 256, exp_lc: 8'h01};
    tbl[7] = '{len: 55,   num: 3, gap: 0, rnd: 1'b0, exp_w: 7,   exp_lc: 8'h02};
    for (int i = 0; i < 6; i++) begin
      tmpl_v[i] = {32'hC0DE_0000 + 32'(i), 32'h1234_5670 + 32'(i)};
    end

    i_reset_n    = 1'b0;
    hdr_wr_en    = 1'b0;
    hdr_wr_addr  = '0;
    hdr_wr_data  = '0;
    cfg_byte_len = '0;
    cfg_num_pkts = '0;
    cfg_gap      = '0;
    cfg_dst_port = 16'h0004;
    start        = 1'b0;
    stop         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset_n = 1'b1;

    @(negedge clk);
    check("rst out_wr", 64'(out_wr), 64'd0);
    check("rst out_data", out_data, 64'd0);
    check("rst out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst cfg_err", 64'(cfg_err), 64'd0);
    check("rst pkt_count", 64'(pkt_count), 64'd0);

    wr_tmpl();

    // Table-driven runs.
    for (int i = 0; i < 8; i++) begin
      clear_cap();
      rdy_rand = tbl[i].rnd;
      start_run(tbl[i].len, tbl[i].num, tbl[i].gap);
      wait_idle($sformatf("vec%0d", i));
      rdy_rand = 1'b0;
      check_capture($sformatf("vec%0d", i), tbl[i].len, tbl[i].num, tbl[i].exp_w,
                    tbl[i].exp_lc, tbl[i].gap, !tbl[i].rnd, exp_cnt);
      if (i == 0 && cap_d.size() > 0) begin
        check("vec0 mod_hdr literal", cap_d[0], 64'h0004_0008_0000_0040);
      end
      exp_cnt += tbl[i].num;
      check($sformatf("vec%0d pkt_count", i), 64'(pkt_count), 64'(exp_cnt));
    end

    // Out-of-range lengths are rejected with a single cfg_err pulse.
    for (int i = 0; i < 3; i++) begin
      int bad_len;
      bad_len = (i == 0) ? 40 : (i == 1) ? 3000 : 47;
      clear_cap();
      start_run(bad_len, 1, 0);
      @(negedge clk);
      check($sformatf("err%0d cfg_err pulse", i), 64'(cfg_err), 64'd1);
      check($sformatf("err%0d busy", i), 64'(busy), 64'd0);
      @(negedge clk);
      check($sformatf("err%0d cfg_err clear", i), 64'(cfg_err), 64'd0);
      check($sformatf("err%0d no words", i), 64'(cap_d.size()), 64'd0);
    end

    // Start and template write while busy are both ignored.
    clear_cap();
    start_run(64, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    cfg_byte_len = 16'd100;
    start        = 1'b1;
    hdr_wr_en    = 1'b1;
    hdr_wr_addr  = 3'd0;
    hdr_wr_data  = '1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    hdr_wr_en = 1'b0;
    wait_idle("busy_start");
    check_capture("busy_start", 64, 1, 8, 8'h01, 0, 1'b1, exp_cnt);
    exp_cnt += 1;
    check("busy_start cfg_err", 64'(cfg_err), 64'd0);

    // Continuous run, stop mid-payload: current packet completes.
    clear_cap();
    start_run(100, 0, 0);
    wait_words("stop_pay", 9);
    pulse_stop();
    wait_idle("stop_pay");
    check_capture("stop_pay", 100, 1, 13, 8'h10, 0, 1'b1, exp_cnt);
    exp_cnt += 1;
    check("stop_pay pkt_count", 64'(pkt_count), 64'(exp_cnt));

    // Continuous run, stop during the gap ends the run at once.
    clear_cap();
    start_run(48, 0, 20);
    wait_words("stop_gap", 7);
    repeat (3) @(posedge clk);
    pulse_stop();
    @(negedge clk);
    check("stop_gap busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_capture("stop_gap", 48, 1, 6, 8'h01, 0, 1'b1, exp_cnt);
    exp_cnt += 1;

    // Reset mid-packet aborts immediately.
    clear_cap();
    start_run(100, 1, 0);
    wait_words("rst_mid", 4);
    @(posedge clk);
    #1;
    i_reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid out_wr", 64'(out_wr), 64'd0);
    check("rst_mid out_data", out_data, 64'd0);
    check("rst_mid out_ctrl", 64'(out_ctrl), 64'd0);
    check("rst_mid busy", 64'(busy), 64'd0);
    check("rst_mid pkt_count", 64'(pkt_count), 64'd0);
    @(posedge clk);
    #1;
    i_reset_n = 1'b1;
    exp_cnt   = 0;

    // Recovery after reset.
    wr_tmpl();
    clear_cap();
    start_run(48, 1, 0);
    wait_idle("post_rst");
    check_capture("post_rst", 48, 1, 6, 8'h01, 0, 1'b1, exp_cnt);
    check("post_rst pkt_count", 64'(pkt_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
